// File: rtl/morse_pkg.sv
// Shared encodings for the Morse key-event decoder: symbol codes, key-event codes and decoder states.
package morse_pkg;

    localparam logic [1:0] SYM_DOT  = 2'd0;
    localparam logic [1:0] SYM_DASH = 2'd1;
    localparam logic [1:0] SYM_LGAP = 2'd2;
    localparam logic [1:0] SYM_WGAP = 2'd3;

    localparam logic [1:0] EV_NONE    = 2'd0;
    localparam logic [1:0] EV_PRESS   = 2'd1;
    localparam logic [1:0] EV_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        GAP     = 2'd2
    } dec_state_t;

endpackage

// File: rtl/morse_sym_fifo.sv
// First-word-fall-through symbol FIFO; a push into a full FIFO succeeds only when a pop frees a slot.
module morse_sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/morse_event_decoder.sv
// Times key-down/key-up periods in Morse units and queues dot/dash/gap symbols.
// Define MORSE_EVENT_DECODER_STATS_EN to add the sym_count and drop_count ports.
//
// state   | meaning
// IDLE    | key up, no gap pending; waits for a press
// PRESSED | key down; timing the press
// GAP     | key up after a symbol; timing the silence
module morse_event_decoder
    import morse_pkg::*;
#(
    parameter int FREQUENCY    = 12_000_000,
    parameter int UNIT_TICKS   = 720_000,
    parameter int DASH_UNITS   = 2,
    parameter int LETTER_UNITS = 3,
    parameter int WORD_UNITS   = 7,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  key_event,
    output logic [1:0]  sym_data,
    output logic        sym_valid,
    input  logic        sym_ready,
`ifdef MORSE_EVENT_DECODER_STATS_EN
    output logic [15:0] sym_count,
    output logic [7:0]  drop_count,
`endif
    output logic        overflow
);

    localparam int TW = $clog2(UNIT_TICKS);
    localparam int UW = $clog2(WORD_UNITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);
    localparam logic [UW-1:0] UNIT_MAX  = UW'(WORD_UNITS);

    if (FREQUENCY < 1 || UNIT_TICKS < 2 || WORD_UNITS <= LETTER_UNITS ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("morse_event_decoder: illegal parameter set");
    end

    dec_state_t    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, tick_step;
    logic [UW-1:0] unit_q, unit_d, unit_step;
    logic          overflow_q, overflow_d;
    logic          wrap;
    logic          push;
    logic [1:0]    push_sym;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop;

    // Step values used whenever a period keeps running; units saturate at the word threshold.
    always_comb begin
        wrap      = (tick_q == TICK_LAST);
        tick_step = wrap ? '0 : tick_q + 1'b1;
        unit_step = (wrap && unit_q != UNIT_MAX) ? unit_q + 1'b1 : unit_q;
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        unit_d   = unit_q;
        push     = 1'b0;
        push_sym = SYM_DOT;
        case (state_q)
            IDLE: begin
                if (key_event == EV_PRESS) begin
                    state_d = PRESSED;
                    tick_d  = '0;
                    unit_d  = '0;
                end
            end
            PRESSED: begin
                if (key_event == EV_RELEASE) begin
                    push     = 1'b1;
                    push_sym = (unit_step >= UW'(DASH_UNITS)) ? SYM_DASH : SYM_DOT;
                    state_d  = GAP;
                    tick_d   = '0;
                    unit_d   = '0;
                end else begin
                    tick_d = tick_step;
                    unit_d = unit_step;
                end
            end
            GAP: begin
                if (key_event == EV_PRESS) begin
                    state_d = PRESSED;
                    tick_d  = '0;
                    unit_d  = '0;
                end else begin
                    tick_d = tick_step;
                    unit_d = unit_step;
                    // Each threshold is crossed exactly once per silence, so no extra "sent" flag is needed.
                    if (wrap && unit_q == UW'(LETTER_UNITS - 1)) begin
                        push     = 1'b1;
                        push_sym = SYM_LGAP;
                    end else if (wrap && unit_q == UW'(WORD_UNITS - 1)) begin
                        push     = 1'b1;
                        push_sym = SYM_WGAP;
                        state_d  = IDLE;
                        tick_d   = '0;
                        unit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                unit_d  = '0;
            end
        endcase
    end

    assign sym_valid  = !fifo_empty;
    assign pop        = sym_valid && sym_ready;
    assign drop       = push && fifo_full && !pop;
    assign overflow_d = overflow_q | drop;
    assign overflow   = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            unit_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            unit_q     <= unit_d;
            overflow_q <= overflow_d;
        end
    end

    morse_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_sym),
        .pop       (pop),
        .rd_data   (sym_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MORSE_EVENT_DECODER_STATS_EN
    logic [15:0] sym_count_q, sym_count_d;
    logic [7:0]  drop_count_q, drop_count_d;

    always_comb begin
        sym_count_d  = sym_count_q;
        drop_count_d = drop_count_q;
        if (push && !drop) begin
            sym_count_d = sym_count_q + 16'd1;
        end
        if (drop && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            sym_count_q  <= sym_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign sym_count  = sym_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_morse_event_decoder.sv
// Directed bench for morse_event_decoder with UNIT_TICKS=4; expected symbols are hand-derived.
module tb_morse_event_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  key_event;
    logic [1:0]  sym_data;
    logic        sym_valid;
    logic        sym_ready;
    logic        overflow;
`ifdef MORSE_EVENT_DECODER_STATS_EN
    logic [15:0] sym_count;
    logic [7:0]  drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    int got_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    morse_event_decoder #(
        .UNIT_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_event  (key_event),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
`ifdef MORSE_EVENT_DECODER_STATS_EN
        .sym_count  (sym_count),
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    // Collect every accepted symbol between clock edges.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sym_valid === 1'b1 && sym_ready === 1'b1)
            got_q.push_back(int'(sym_data));
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [1:0] code);
        key_event = code;
        step(1);
        key_event = 2'd0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        key_event = 2'd0;
        step(2);
        rst_n = 1'b1;
        step(1);
        got_q.delete();
    endtask

    task automatic check_syms(input string tag);
        chk_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk_eq($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        key_event = 2'd0;
        sym_ready = 1'b1;
        step(2);
        chk_eq("rst_valid", sym_valid, 1'b0);
        chk_eq("rst_data", sym_data, 2'd0);
        chk_eq("rst_overflow", overflow, 1'b0);
`ifdef MORSE_EVENT_DECODER_STATS_EN
        chk_eq("rst_sym_count", sym_count, 16'd0);
        chk_eq("rst_drop_count", drop_count, 8'd0);
`endif
        rst_n = 1'b1;
        step(1);
        got_q.delete();

        // Idle, stray release and reserved code produce nothing.
        step(20);
        ev(2'd2);
        ev(2'd3);
        step(30);
        exp_q = '{};
        check_syms("idle");

        // Dot: release 5 cycles after press, visible one cycle later.
        ev(2'd1);
        step(4);
        ev(2'd2);
        chk_eq("dot_valid", sym_valid, 1'b1);
        chk_eq("dot_data", sym_data, 2'd0);
        step(11);
        chk_eq("pre_lgap_valid", sym_valid, 1'b0);
        step(1);
        chk_eq("lgap_valid", sym_valid, 1'b1);
        chk_eq("lgap_data", sym_data, 2'd2);
        step(15);
        chk_eq("pre_wgap_valid", sym_valid, 1'b0);
        step(1);
        chk_eq("wgap_valid", sym_valid, 1'b1);
        chk_eq("wgap_data", sym_data, 2'd3);
        step(30);
        exp_q = '{0, 2, 3};
        check_syms("dot_gaps");

        // Dash: key held 9 cycles.
        ev(2'd1);
        step(8);
        ev(2'd2);
        chk_eq("dash_valid", sym_valid, 1'b1);
        chk_eq("dash_data", sym_data, 2'd1);
        step(40);
        exp_q = '{1, 2, 3};
        check_syms("dash_gaps");

        // Two-unit silence between dots yields no gap symbol.
        ev(2'd1);
        step(4);
        ev(2'd2);
        step(7);
        ev(2'd1);
        step(3);
        ev(2'd2);
        step(2);
        exp_q = '{0, 0};
        check_syms("short_gap");
        step(40);
        got_q.delete();

        // Overflow: five dots into a stalled 4-entry FIFO, then drain.
        do_reset();
        sym_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev(2'd1);
            ev(2'd2);
        end
        chk_eq("full_valid", sym_valid, 1'b1);
        chk_eq("full_no_overflow", overflow, 1'b0);
        ev(2'd1);
        ev(2'd2);
        chk_eq("overflow_set", overflow, 1'b1);
        sym_ready = 1'b1;
        step(6);
        exp_q = '{0, 0, 0, 0};
        check_syms("drain");
        chk_eq("drained_valid", sym_valid, 1'b0);
`ifdef MORSE_EVENT_DECODER_STATS_EN
        chk_eq("drop_count", drop_count, 8'd1);
        chk_eq("sym_count", sym_count, 16'd4);
`endif
        step(40);
        exp_q = '{2, 3};
        check_syms("post_drain_gaps");
        chk_eq("overflow_sticky", overflow, 1'b1);
`ifdef MORSE_EVENT_DECODER_STATS_EN
        chk_eq("sym_count_final", sym_count, 16'd6);
        chk_eq("drop_count_final", drop_count, 8'd1);
`endif

        // Push into a full FIFO on the same edge as a pop is accepted.
        do_reset();
        chk_eq("reset_clears_overflow", overflow, 1'b0);
        sym_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev(2'd1);
            ev(2'd2);
        end
        ev(2'd1);
        key_event = 2'd2;
        sym_ready = 1'b1;
        step(1);
        key_event = 2'd0;
        chk_eq("push_pop_full_overflow", overflow, 1'b0);
        step(8);
        exp_q = '{0, 0, 0, 0, 0};
        check_syms("push_pop_full");
        step(40);
        got_q.delete();

        // Reset during a press discards it; the decoder then works from IDLE.
        do_reset();
        ev(2'd1);
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        ev(2'd2);
        step(40);
        chk_eq("mid_reset_valid", sym_valid, 1'b0);
        exp_q = '{};
        check_syms("mid_reset");
        ev(2'd1);
        ev(2'd2);
        chk_eq("after_reset_dot_valid", sym_valid, 1'b1);
        chk_eq("after_reset_dot_data", sym_data, 2'd0);
        step(40);
        exp_q = '{0, 2, 3};
        check_syms("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
